exec_operand_stage: RTL and testbench

- Registered execute-stage operand selector: successor to the combinational srcb mux, parametrised in data width and forwarding-source count.
- Selects ALU operand A and operand B from register, PC, immediate, constant or zero, and resolves register operands through a prioritised forwarding network.
- Stalls on pending (load-use) forwards and presents resolved operands to the ALU/MDU over a valid/ready handshake with a one-entry holding register.

---
 rtl/exec_operand_stage.sv | 193 +++++++++++++++++++
 tb/tb_exec_operand_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_operand_stage.sv
// rtl/exec_operand_stage.sv - registered execute-stage operand selector with prioritised forwarding
// Optional macro OPSEL_WORD_EN: sign-extend srca/srcb from bit 31 for W-type operations.
module exec_operand_stage #(
  parameter int XLEN       = 64,
  parameter int NFWD       = 3,
  parameter int LINK_CONST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [XLEN-1:0]        in_rv1,
  input  logic [XLEN-1:0]        in_rv2,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_imm,
  input  logic [1:0]             in_sel_a,
  input  logic [1:0]             in_sel_b,
  input  logic                   in_wop,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD-1:0]        fwd_pending,
  input  logic [NFWD*5-1:0]      fwd_rd,
  input  logic [NFWD*XLEN-1:0]   fwd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_srca,
  output logic [XLEN-1:0]        out_srcb,
  output logic [XLEN-1:0]        out_stdata,
  output logic                   out_wop,
  output logic [15:0]            stall_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [4:0]      rs1_q, rs2_q;
  logic [XLEN-1:0] rv1_q, rv2_q, pc_q, imm_q;
  logic [1:0]      sel_a_q, sel_b_q;
  logic            wop_q;
  logic [XLEN-1:0] srca_q, srcb_q, stdata_q;
  logic            owop_q;
  logic [15:0]     stall_q;

  // WAIT re-scans the captured entry; otherwise the offered instruction is resolved.
  logic            use_cap;
  logic [4:0]      c_rs1, c_rs2;
  logic [XLEN-1:0] c_rv1, c_rv2, c_pc, c_imm;
  logic [1:0]      c_sel_a, c_sel_b;
  logic            c_wop;

  assign use_cap = (state_q == S_WAIT);
  assign c_rs1   = use_cap ? rs1_q   : in_rs1;
  assign c_rs2   = use_cap ? rs2_q   : in_rs2;
  assign c_rv1   = use_cap ? rv1_q   : in_rv1;
  assign c_rv2   = use_cap ? rv2_q   : in_rv2;
  assign c_pc    = use_cap ? pc_q    : in_pc;
  assign c_imm   = use_cap ? imm_q   : in_imm;
  assign c_sel_a = use_cap ? sel_a_q : in_sel_a;
  assign c_sel_b = use_cap ? sel_b_q : in_sel_b;
  assign c_wop   = use_cap ? wop_q   : in_wop;

  // Returns {pending, data}; the youngest matching source wins even if it is pending.
  function automatic logic [XLEN:0] resolve(input logic [4:0] rs, input logic [XLEN-1:0] rv);
    logic            hit;
    logic [XLEN:0]   r;
    hit = 1'b0;
    r   = '0;
    if (rs != 5'd0) r[XLEN-1:0] = rv;
    for (int i = 0; i < NFWD; i++) begin
      if (!hit && rs != 5'd0 && fwd_valid[i] && fwd_rd[5*i +: 5] == rs) begin
        hit = 1'b1;
        r   = {fwd_pending[i], fwd_data[XLEN*i +: XLEN]};
      end
    end
    return r;
  endfunction

  logic [XLEN:0]   res1, res2;
  logic            pend;
  logic [XLEN-1:0] op_a, op_b;

  always_comb begin
    res1 = resolve(c_rs1, c_rv1);
    res2 = resolve(c_rs2, c_rv2);
    pend = ((c_sel_a == 2'd0) && res1[XLEN]) || res2[XLEN];
    case (c_sel_a)
      2'd0:    op_a = res1[XLEN-1:0];
      2'd1:    op_a = c_pc;
      default: op_a = '0;
    endcase
    case (c_sel_b)
      2'd0:    op_b = res2[XLEN-1:0];
      2'd1:    op_b = c_imm;
      2'd2:    op_b = XLEN'(LINK_CONST);
      default: op_b = '0;
    endcase
`ifdef OPSEL_WORD_EN
    if (c_wop) begin
      op_a = {{(XLEN-32){op_a[31]}}, op_a[31:0]};
      op_b = {{(XLEN-32){op_b[31]}}, op_b[31:0]};
    end
`endif
  end

  logic accept, capture, latch;

  assign in_ready = (state_q == S_EMPTY) || ((state_q == S_FULL) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    latch   = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY, S_FULL: begin
          if (accept) begin
            capture = 1'b1;
            if (pend) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_FULL;
              latch   = 1'b1;
            end
          end else if (state_q == S_FULL && out_ready) begin
            state_d = S_EMPTY;
          end
        end
        S_WAIT: begin
          if (!pend) begin
            state_d = S_FULL;
            latch   = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_EMPTY;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rv1_q    <= '0;
      rv2_q    <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      sel_a_q  <= '0;
      sel_b_q  <= '0;
      wop_q    <= 1'b0;
      srca_q   <= '0;
      srcb_q   <= '0;
      stdata_q <= '0;
      owop_q   <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        rs1_q   <= in_rs1;
        rs2_q   <= in_rs2;
        rv1_q   <= in_rv1;
        rv2_q   <= in_rv2;
        pc_q    <= in_pc;
        imm_q   <= in_imm;
        sel_a_q <= in_sel_a;
        sel_b_q <= in_sel_b;
        wop_q   <= in_wop;
      end
      if (latch) begin
        srca_q   <= op_a;
        srcb_q   <= op_b;
        stdata_q <= res2[XLEN-1:0];
        owop_q   <= c_wop;
      end
      if (state_q == S_WAIT && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign out_valid  = (state_q == S_FULL);
  assign out_srca   = srca_q;
  assign out_srcb   = srcb_q;
  assign out_stdata = stdata_q;
  assign out_wop    = owop_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_exec_operand_stage.sv
// tb/tb_exec_operand_stage.sv - directed vector bench for exec_operand_stage
module tb_exec_operand_stage;

  localparam int XLEN = 64;
  localparam int NFWD = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush, in_valid, in_ready, in_wop;
  logic [4:0]        in_rs1, in_rs2;
  logic [XLEN-1:0]   in_rv1, in_rv2, in_pc, in_imm;
  logic [1:0]        in_sel_a, in_sel_b;
  logic [NFWD-1:0]   fwd_valid, fwd_pending;
  logic [NFWD*5-1:0] fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic              out_valid, out_ready, out_wop;
  logic [XLEN-1:0]   out_srca, out_srcb, out_stdata;
  logic [15:0]       stall_cnt;

  exec_operand_stage #(.XLEN(XLEN), .NFWD(NFWD), .LINK_CONST(4)) dut (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rv1(in_rv1), .in_rv2(in_rv2),
    .in_pc(in_pc), .in_imm(in_imm), .in_sel_a(in_sel_a), .in_sel_b(in_sel_b),
    .in_wop(in_wop),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_srca(out_srca), .out_srcb(out_srcb), .out_stdata(out_stdata),
    .out_wop(out_wop), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [63:0] rv1, rv2, pc, imm;
    logic [1:0]  sa, sb;
    logic        wop;
    logic [2:0]  fv, fp;
    logic [4:0]  fr0, fr1, fr2;
    logic [63:0] fd0, fd1, fd2;
    logic [63:0] ea, eb, es;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_rv1 = v.rv1; in_rv2 = v.rv2;
    in_pc = v.pc; in_imm = v.imm; in_sel_a = v.sa; in_sel_b = v.sb; in_wop = v.wop;
    fwd_valid = v.fv; fwd_pending = v.fp;
    fwd_rd = {v.fr2, v.fr1, v.fr0};
    fwd_data = {v.fd2, v.fd1, v.fd0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];
  vec_t v_load, v_jal;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    // rs1 rs2 rv1 rv2 pc imm sa sb wop fv fp fr0 fr1 fr2 fd0 fd1 fd2 exp_a exp_b exp_st
    vecs[0] = '{5'd5, 5'd0, 64'h10, 64'h99, 64'h100, 64'hFFFF_FFFF_FFFF_FFFD, 2'd0, 2'd1, 1'b0,
                3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0,
                64'h10, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0};
    vecs[1] = '{5'd7, 5'd2, 64'h70, 64'h22, 64'h0, 64'h0, 2'd0, 2'd0, 1'b0,
                3'b101, 3'b000, 5'd7, 5'd7, 5'd7, 64'hAA, 64'hCC, 64'hBB,
                64'hAA, 64'h22, 64'h22};
    vecs[2] = '{5'd0, 5'd0, 64'h77, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 1'b0,
                3'b001, 3'b000, 5'd0, 5'd0, 5'd0, 64'h55, 64'h0, 64'h0,
                64'h0, 64'h0, 64'h0};
    vecs[3] = '{5'd0, 5'd0, 64'h0, 64'h0, 64'h8000_0000, 64'h0, 2'd1, 2'd2, 1'b0,
                3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0,
                64'h8000_0000, 64'h4, 64'h0};
    vecs[4] = '{5'd1, 5'd4, 64'h123, 64'h44, 64'h0, 64'h0, 2'd2, 2'd3, 1'b0,
                3'b011, 3'b000, 5'd9, 5'd4, 5'd0, 64'h90, 64'hD0, 64'h0,
                64'h0, 64'h0, 64'hD0};
    vecs[5] = '{5'd1, 5'd6, 64'h123, 64'h66, 64'h0, 64'h0, 2'd3, 2'd0, 1'b0,
                3'b100, 3'b000, 5'd6, 5'd0, 5'd6, 64'hF0, 64'h0, 64'hE6,
                64'h0, 64'hE6, 64'hE6};
`ifdef OPSEL_WORD_EN
    vecs[6] = '{5'd8, 5'd0, 64'h1_8000_0000, 64'h0, 64'h0, 64'h1_0000_0005, 2'd0, 2'd1, 1'b1,
                3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0,
                64'hFFFF_FFFF_8000_0000, 64'h5, 64'h0};
`else
    vecs[6] = '{5'd8, 5'd0, 64'h1_8000_0000, 64'h0, 64'h0, 64'h1_0000_0005, 2'd0, 2'd1, 1'b1,
                3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0,
                64'h1_8000_0000, 64'h1_0000_0005, 64'h0};
`endif
    vecs[7] = '{5'd3, 5'd0, 64'h31, 64'h0, 64'h400, 64'h8, 2'd1, 2'd1, 1'b0,
                3'b001, 3'b001, 5'd3, 5'd0, 5'd0, 64'hDEAD, 64'h0, 64'h0,
                64'h400, 64'h8, 64'h0};
    vecs[8] = '{5'd0, 5'd3, 64'h0, 64'h30, 64'h0, 64'h0, 2'd0, 2'd0, 1'b0,
                3'b011, 3'b010, 5'd3, 5'd3, 5'd0, 64'h33, 64'h44, 64'h0,
                64'h0, 64'h33, 64'h33};

    v_load = '{5'd0, 5'd3, 64'h0, 64'h99, 64'h0, 64'h0, 2'd0, 2'd0, 1'b0,
               3'b001, 3'b001, 5'd3, 5'd0, 5'd0, 64'hDEAD, 64'h0, 64'h0,
               64'h0, 64'h1234, 64'h1234};
    v_jal = vecs[3];

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_srca", out_srca, 64'h0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    step(); step();
    rst_n = 1'b1;

    // Back-to-back vectors with out_ready held high
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      step();
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'h1);
      chk($sformatf("v%0d_srca", i), out_srca, vecs[i].ea);
      chk($sformatf("v%0d_srcb", i), out_srcb, vecs[i].eb);
      chk($sformatf("v%0d_stdata", i), out_stdata, vecs[i].es);
      chk($sformatf("v%0d_wop", i), 64'(out_wop), 64'(vecs[i].wop));
    end
    in_valid = 1'b0;
    fwd_valid = '0;
    step();
    chk("drain_out_valid", 64'(out_valid), 64'h0);

    // Load-use: pending during accept and first WAIT cycle
    drive(v_load);
    in_valid = 1'b1;
    step();
    chk("lu_wait1_valid", 64'(out_valid), 64'h0);
    chk("lu_wait1_in_ready", 64'(in_ready), 64'h0);
    in_valid = 1'b0;
    step();
    chk("lu_wait2_valid", 64'(out_valid), 64'h0);
    chk("lu_wait2_in_ready", 64'(in_ready), 64'h0);
    fwd_pending = 3'b000;
    fwd_data = {64'h0, 64'h0, 64'h1234};
    step();
    chk("lu_full_valid", 64'(out_valid), 64'h1);
    chk("lu_srcb", out_srcb, 64'h1234);
    chk("lu_stdata", out_stdata, 64'h1234);
    chk("lu_stall_cnt", 64'(stall_cnt), 64'h2);

    // JAL accepted back-to-back, then held under backpressure
    drive(v_jal);
    in_valid = 1'b1;
    step();
    chk("jal_srca", out_srca, 64'h8000_0000);
    chk("jal_srcb", out_srcb, 64'h4);
    out_ready = 1'b0;
    drive(vecs[0]);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("hold%0d_valid", c), 64'(out_valid), 64'h1);
      chk($sformatf("hold%0d_in_ready", c), 64'(in_ready), 64'h0);
      chk($sformatf("hold%0d_srca", c), out_srca, 64'h8000_0000);
      chk($sformatf("hold%0d_srcb", c), out_srcb, 64'h4);
    end
    out_ready = 1'b1;
    step();
    chk("b2b_valid", 64'(out_valid), 64'h1);
    chk("b2b_srca", out_srca, 64'h10);
    chk("b2b_srcb", out_srcb, 64'hFFFF_FFFF_FFFF_FFFD);

    // Flush in FULL with a simultaneous accept
    drive(v_jal);
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    chk("flfull_valid", 64'(out_valid), 64'h0);
    chk("flfull_in_ready", 64'(in_ready), 64'h1);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("flfull_nocap", 64'(out_valid), 64'h0);

    // Flush in WAIT with in_valid asserted
    drive(v_load);
    in_valid = 1'b1;
    step();
    chk("flwait_enter", 64'(out_valid), 64'h0);
    drive(vecs[0]);
    fwd_valid = 3'b001; fwd_pending = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd3};
    flush = 1'b1;
    step();
    chk("flwait_valid", 64'(out_valid), 64'h0);
    chk("flwait_in_ready", 64'(in_ready), 64'h1);
    chk("flwait_stall_cnt", 64'(stall_cnt), 64'h3);
    flush = 1'b0;
    in_valid = 1'b0;
    fwd_pending = 3'b000;
    step();
    chk("flwait_nocap", 64'(out_valid), 64'h0);

    // Asynchronous reset while FULL
    drive(vecs[6]);
    in_valid = 1'b1;
    step();
    chk("prerst_valid", 64'(out_valid), 64'h1);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_srca", out_srca, 64'h0);
    chk("arst_srcb", out_srcb, 64'h0);
    chk("arst_stdata", out_stdata, 64'h0);
    chk("arst_wop", 64'(out_wop), 64'h0);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'h0);
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
